// File: rtl/noc_rx_mailbox.sv
// noc_rx_mailbox: receive-side FIFO between the NoC input path and an Avalon-MM
// slave. It captures every NoC word once, flags drops on overflow, and raises
// a level interrupt while data is pending or an overflow is latched.
module noc_rx_mailbox #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              noc_valid,
  input  logic [DATA_W-1:0] noc_data,
  output logic              noc_ready,
  input  logic [1:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_CTRL = 2'd2;
  localparam logic [1:0] A_PEEK = 2'd3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          irq_en_q, irq_en_d;
  logic [31:0]   readdata_q, readdata_d;

  logic full, empty, push, pop, ovf_set, ovf_clr;
  logic [31:0] head_word, status_word;

  // Only bit2 of a STATUS write and bit0 of a CONTROL write carry meaning.
  logic unused_wd;
  assign unused_wd = ^{writedata[31:3], writedata[1]};

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // Ready and irq look only at registered state, so no input reaches them
  // combinationally; a pop from full frees a slot one cycle later.
  assign noc_ready = ~full;
  assign irq       = irq_en_q & (~empty | ovf_q);
  assign readdata  = readdata_q;

  assign push    = noc_valid & ~full;
  assign pop     = read & (address == A_DATA) & ~empty;
  assign ovf_set = noc_valid & full;
  assign ovf_clr = write & (address == A_STAT) & writedata[2];

  assign head_word   = empty ? 32'h0 : 32'(mem[rd_ptr_q]);
  assign status_word = {16'h0, 8'(count_q), 4'h0, irq, ovf_q, full, empty};

  // Next-state for pointers, occupancy, sticky overflow, control and read mux.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    irq_en_d   = irq_en_q;
    readdata_d = 32'h0;

    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // A new drop in the same cycle as a W1C clear keeps the flag set.
    if (ovf_set)      ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;

    if (write && address == A_CTRL) irq_en_d = writedata[0];

    // readdata tracks the addressed register every cycle, pre-pop values.
    case (address)
      A_DATA:  readdata_d = head_word;
      A_STAT:  readdata_d = status_word;
      A_CTRL:  readdata_d = {31'h0, irq_en_q};
      A_PEEK:  readdata_d = head_word;
      default: readdata_d = 32'h0;
    endcase
  end

  // Control and status registers; reset clears everything except storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      irq_en_q   <= 1'b0;
      readdata_q <= 32'h0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      irq_en_q   <= irq_en_d;
      readdata_q <= readdata_d;
    end
  end

  // FIFO storage write; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= noc_data;
  end

endmodule

// File: tb/tb_noc_rx_mailbox.sv
// Bench for noc_rx_mailbox: a queue-based model checked every cycle, directed
// scenarios with literal expectations, and a randomized traffic phase.
module tb_noc_rx_mailbox;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        noc_valid = 1'b0;
  logic [31:0] noc_data = '0;
  logic        noc_ready;
  logic [1:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        irq;

  noc_rx_mailbox #(.DEPTH(DEPTH), .DATA_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .noc_valid(noc_valid), .noc_data(noc_data), .noc_ready(noc_ready),
    .address(address), .read(read), .write(write), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] mq[$];
  bit          m_ovf = 0;
  bit          m_en  = 0;
  logic [31:0] m_rd  = '0;

  function automatic logic [31:0] m_status();
    int n;
    logic iv;
    n  = mq.size();
    iv = m_en && (n != 0 || m_ovf);
    return {16'h0, 8'(n), 4'h0, iv, 1'(m_ovf), 1'(n == DEPTH), 1'(n == 0)};
  endfunction

  always @(negedge reset_n) begin
    mq.delete();
    m_ovf = 0;
    m_en  = 0;
    m_rd  = '0;
  end

  always @(posedge clk) begin : model
    int n;
    bit full, empty;
    if (reset_n) begin
      n = mq.size();
      full = (n == DEPTH);
      empty = (n == 0);
      case (address)
        2'd0, 2'd3: m_rd = empty ? 32'h0 : mq[0];
        2'd1:       m_rd = m_status();
        default:    m_rd = {31'h0, m_en};
      endcase
      if (read && address == 2'd0 && !empty) void'(mq.pop_front());
      if (noc_valid && !full) mq.push_back(noc_data);
      if (noc_valid && full) m_ovf = 1;
      else if (write && address == 2'd1 && writedata[2]) m_ovf = 0;
      if (write && address == 2'd2) m_en = writedata[0];
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("cyc_readdata", readdata, m_rd);
      chk("cyc_noc_ready", {31'h0, noc_ready}, {31'h0, 1'(mq.size() != DEPTH)});
      chk("cyc_irq", {31'h0, irq}, {31'h0, 1'(m_en && (mq.size() != 0 || m_ovf))});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    noc_valid = 0; read = 0; write = 0;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] w);
    noc_valid = 1; noc_data = w;
    @(posedge clk); #1;
    noc_valid = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a; read = 1;
    @(posedge clk); #1;
    read = 0;
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address = a; write = 1; writedata = d;
    @(posedge clk); #1;
    write = 0;
  endtask

  logic [31:0] d;
  logic [31:0] got[$];

  initial begin
    // reset
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'h0, noc_ready}, 32'h1);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    @(negedge clk);
    reset_n = 1;
    #1;
    chk("rel_readdata", readdata, 32'h0);
    rd(2'd1, d); chk("rst_status", d, 32'h1);

    // ordering
    push(32'hA0000001); push(32'hA0000002); push(32'hA0000003);
    rd(2'd0, d); chk("ord_0", d, 32'hA0000001);
    rd(2'd0, d); chk("ord_1", d, 32'hA0000002);
    rd(2'd0, d); chk("ord_2", d, 32'hA0000003);
    rd(2'd1, d); chk("ord_status", d, 32'h1);
    rd(2'd0, d); chk("ord_empty_read", d, 32'h0);

    // full / overflow
    for (int i = 0; i < 8; i++) push(32'hB0 + i);
    chk("full_ready", {31'h0, noc_ready}, 32'h0);
    rd(2'd1, d); chk("full_status", d, 32'h802);
    push(32'hDEADBEEF);
    rd(2'd1, d); chk("ovf_status", d, 32'h806);
    for (int i = 0; i < 8; i++) begin
      rd(2'd0, d); chk("drain_word", d, 32'hB0 + i);
    end
    rd(2'd1, d); chk("drain_status", d, 32'h5);
    wr(2'd1, 32'h4);
    rd(2'd1, d); chk("w1c_status", d, 32'h1);

    // interrupt
    wr(2'd2, 32'h1);
    idle();
    chk("irq_en_empty", {31'h0, irq}, 32'h0);
    push(32'hE1);
    chk("irq_after_push", {31'h0, irq}, 32'h1);
    rd(2'd3, d); chk("peek_word", d, 32'hE1);
    chk("irq_after_peek", {31'h0, irq}, 32'h1);
    rd(2'd0, d); chk("pop_word", d, 32'hE1);
    chk("irq_after_pop", {31'h0, irq}, 32'h0);

    // concurrent push + pop at count 4
    for (int i = 0; i < 4; i++) push(32'hC0 + i);
    noc_valid = 1; noc_data = 32'hC4; address = 2'd0; read = 1;
    @(posedge clk); #1;
    noc_valid = 0; read = 0;
    chk("conc_pop", readdata, 32'hC0);
    rd(2'd1, d); chk("conc_status", d, 32'h408);
    for (int i = 1; i < 5; i++) begin
      rd(2'd0, d); chk("conc_drain", d, 32'hC0 + i);
    end
    wr(2'd2, 32'h0);

    // streaming across pointer wrap
    begin
      int sent;
      bit rdprev;
      sent = 0;
      got.delete();
      for (int c = 0; c < 200 && got.size() < 20; c++) begin
        noc_valid = (sent < 20) && noc_ready;
        noc_data  = 32'h100 + sent;
        address   = 2'd0;
        read      = c[0] || (sent >= 20);
        rdprev    = read;
        @(posedge clk); #1;
        if (noc_valid) sent++;
        if (rdprev && readdata != 0) got.push_back(readdata);
      end
      noc_valid = 0; read = 0;
      chk("stream_count", got.size(), 32'd20);
      for (int i = 0; i < got.size(); i++) chk("stream_word", got[i], 32'h100 + i);
    end

    // randomized traffic
    for (int ph = 0; ph < 5; ph++) begin
      int pv, pr;
      pv = $urandom_range(10, 90);
      pr = $urandom_range(10, 90);
      for (int c = 0; c < 300; c++) begin
        noc_valid = ($urandom_range(0, 99) < pv);
        noc_data  = $urandom;
        read      = ($urandom_range(0, 99) < pr);
        address   = 2'($urandom_range(0, 3));
        write     = ($urandom_range(0, 15) == 0);
        writedata = $urandom;
        @(posedge clk); #1;
      end
    end
    idle();

    // reset mid-operation
    @(negedge clk); #1 reset_n = 0; #1 reset_n = 1;
    wr(2'd2, 32'h1);
    for (int i = 0; i < 8; i++) push(32'hD0 + i);
    push(32'h0000DEAD);
    for (int i = 0; i < 3; i++) begin
      rd(2'd0, d); chk("mid_pop", d, 32'hD0 + i);
    end
    rd(2'd1, d); chk("mid_status", d, 32'h50C);
    @(negedge clk); #1 reset_n = 0; #1;
    chk("mid_rst_irq", {31'h0, irq}, 32'h0);
    chk("mid_rst_ready", {31'h0, noc_ready}, 32'h1);
    chk("mid_rst_readdata", readdata, 32'h0);
    #1 reset_n = 1;
    rd(2'd1, d); chk("mid_rst_status", d, 32'h1);
    rd(2'd2, d); chk("mid_rst_ctrl", d, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
